// File: rtl/layer1_sum_accumulator.sv
// Layer-1 multiply-accumulate producer feeding the RELU sumIn/trigger inputs.
// Saturating per-node sums, double-buffered into one packed output word.
module layer1_sum_accumulator #(
    parameter int NODES = 4,
    parameter int TERMS = 16,
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int SUM_W = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic [W_W-1:0]         in_weight,
    output logic [NODES*SUM_W-1:0] sumIn,
    output logic                   trigger,
    output logic                   busy
);

    localparam int PW = IN_W + W_W;
    localparam int TW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TERMS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NODES - 1);

    typedef enum logic [1:0] {
        INIT,
        ACCUM,
        EMIT
    } state_t;

    state_t             state;
    logic [TW-1:0]      term;
    logic [NW-1:0]      node;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   sat;
    logic [SUM_W-1:0]   slot [NODES];
    logic signed [PW-1:0] prod;
    logic [SUM_W:0]     wide;
    logic               accept;

    assign prod = $signed(in_data) * $signed(in_weight);
    assign wide = {acc[SUM_W-1], acc}
                + {{(SUM_W+1-PW){prod[PW-1]}}, prod};
    assign accept = (state == ACCUM) && in_valid && in_ready && !clear;

    // Overflow shows as disagreement between the two top bits of the wide sum.
    always_comb begin
        sat = wide[SUM_W-1:0];
        if (wide[SUM_W] != wide[SUM_W-1]) begin
            if (wide[SUM_W]) begin
                sat = {1'b1, {(SUM_W-1){1'b0}}};
            end else begin
                sat = {1'b0, {(SUM_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            in_ready <= 1'b0;
            trigger  <= 1'b0;
            busy     <= 1'b0;
            sumIn    <= '0;
            term     <= '0;
            node     <= '0;
            acc      <= '0;
            for (int k = 0; k < NODES; k++) begin
                slot[k] <= '0;
            end
        end else begin
            trigger <= 1'b0;
            unique case (state)
                INIT: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                ACCUM: begin
                    if (clear) begin
                        term <= '0;
                        node <= '0;
                        acc  <= '0;
                        busy <= 1'b0;
                        for (int k = 0; k < NODES; k++) begin
                            slot[k] <= '0;
                        end
                    end else if (accept) begin
                        busy <= 1'b1;
                        if (term == T_LAST) begin
                            term       <= '0;
                            acc        <= '0;
                            slot[node] <= sat;
                            if (node == N_LAST) begin
                                // Final node bypasses its slot so sumIn lands with trigger.
                                node     <= '0;
                                state    <= EMIT;
                                in_ready <= 1'b0;
                                trigger  <= 1'b1;
                                busy     <= 1'b0;
                                for (int k = 0; k < NODES; k++) begin
                                    sumIn[k*SUM_W +: SUM_W] <=
                                        (k == NODES - 1) ? sat : slot[k];
                                end
                            end else begin
                                node <= node + 1'b1;
                            end
                        end else begin
                            acc  <= sat;
                            term <= term + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= INIT;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer1_sum_accumulator.sv
// Randomized bench for layer1_sum_accumulator.
// Reference sums come from a plain integer model of the frame.
module tb_layer1_sum_accumulator;

    localparam int NODES = 4;
    localparam int TERMS = 16;
    localparam int IN_W  = 8;
    localparam int W_W   = 8;
    localparam int SUM_W = 18;
    localparam int NB    = NODES * TERMS;
    localparam longint SMAX = (longint'(1) << (SUM_W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (SUM_W - 1));

    logic                   clk;
    logic                   rst_n;
    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_W-1:0]        in_data;
    logic [W_W-1:0]         in_weight;
    logic [NODES*SUM_W-1:0] sumIn;
    logic                   trigger;
    logic                   busy;

    logic          s_clear;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic [7:0]    s_weight;
    logic [35:0]   s_sum;
    logic          s_trigger;
    logic          s_busy;

    layer1_sum_accumulator #(
        .NODES(NODES), .TERMS(TERMS), .IN_W(IN_W),
        .W_W(W_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight),
        .sumIn(sumIn), .trigger(trigger), .busy(busy)
    );

    layer1_sum_accumulator #(
        .NODES(2), .TERMS(2), .IN_W(8), .W_W(8), .SUM_W(18)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_data(s_data), .in_weight(s_weight),
        .sumIn(s_sum), .trigger(s_trigger), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int trig_cnt = 0;
    int trig_cyc[$];
    int stable_err = 0;
    logic [NODES*SUM_W-1:0] last_sum = '0;
    int qa[NB];
    int qw[NB];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trigger) begin
            trig_cnt++;
            trig_cyc.push_back(cyc);
        end
        if (rst_n && !trigger && sumIn !== last_sum) stable_err++;
        last_sum = sumIn;
    end

    function automatic logic [NODES*SUM_W-1:0] model();
        logic [NODES*SUM_W-1:0] r;
        longint acc;
        r = '0;
        for (int n = 0; n < NODES; n++) begin
            acc = 0;
            for (int t = 0; t < TERMS; t++) begin
                acc += longint'(qa[n*TERMS+t]) * qw[n*TERMS+t];
                if (acc > SMAX) acc = SMAX;
                else if (acc < SMIN) acc = SMIN;
            end
            r[n*SUM_W +: SUM_W] = SUM_W'(acc);
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NB; i++) begin
            qa[i] = int'($urandom_range(0, 255)) - 128;
            qw[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic send(input int a, input int w, input int maxgap);
        int g;
        bit rdy;
        bit done;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_data   = IN_W'(a);
        in_weight = W_W'(w);
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: in_ready never seen high");
        end
    endtask

    task automatic run_frame(input string tag, input int maxgap,
                             input bit hold, input bit rnd);
        logic [NODES*SUM_W-1:0] exp;
        if (rnd) fill_random();
        exp = model();
        for (int i = 0; i < NB; i++) begin
            send(qa[i], qw[i], (i == 0) ? 0 : maxgap);
            if (i == 0) begin
                n_total++;
                if (busy !== 1'b1)
                    $display("FAIL %s_busy_rise: got %b need 1", tag, busy);
                else n_pass++;
            end
        end
        n_total++;
        if (trigger !== 1'b1)
            $display("FAIL %s_trigger: got %b need 1", tag, trigger);
        else n_pass++;
        n_total++;
        if (sumIn !== exp)
            $display("FAIL %s_sum: got %h need %h", tag, sumIn, exp);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_emit: ready=%b busy=%b need 0 0",
                     tag, in_ready, busy);
        else n_pass++;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_weight = '0;
        s_clear = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_weight = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b0 || trigger !== 1'b0 || busy !== 1'b0 ||
            sumIn !== '0)
            $display("FAIL reset_vals: rdy=%b trg=%b busy=%b sum=%h need 0",
                     in_ready, trigger, busy, sumIn);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0)
            $display("FAIL reset_ready_early: got %b need 0", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1 || s_ready !== 1'b1)
            $display("FAIL reset_ready_rise: got %b/%b need 1/1",
                     in_ready, s_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int ba[4] = '{3, -2, 10, 1};
        int bw[4] = '{4, 5, 10, -1};
        logic [35:0] exp;
        exp = {18'd99, 18'd2};
        for (int i = 0; i < 4; i++) begin
            s_valid  = 1'b1;
            s_data   = 8'(ba[i]);
            s_weight = 8'(bw[i]);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        n_total++;
        if (s_trigger !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL basic_emit: trg=%b rdy=%b need 1 0",
                     s_trigger, s_ready);
        else n_pass++;
        n_total++;
        if (s_sum !== exp)
            $display("FAIL basic_sum: got %h need %h", s_sum, exp);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (s_trigger !== 1'b0 || s_sum !== exp)
            $display("FAIL basic_pulse: trg=%b sum=%h need 0 %h",
                     s_trigger, s_sum, exp);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NB; i++) begin
            qa[i] = 0;
            qw[i] = 0;
            if (i < TERMS) begin
                qa[i] = -128;
                qw[i] = -128;
            end else if (i < 2 * TERMS) begin
                qa[i] = 127;
                qw[i] = -128;
            end
        end
        run_frame("sat", 0, 0, 0);
        n_total++;
        if (sumIn[SUM_W-1:0] !== 18'h1FFFF)
            $display("FAIL sat_pos: got %h need 1ffff", sumIn[SUM_W-1:0]);
        else n_pass++;
        n_total++;
        if (sumIn[2*SUM_W-1:SUM_W] !== 18'h20000)
            $display("FAIL sat_neg: got %h need 20000",
                     sumIn[2*SUM_W-1:SUM_W]);
        else n_pass++;
        n_total++;
        if (sumIn[4*SUM_W-1:2*SUM_W] !== '0)
            $display("FAIL sat_zero: got %h need 0",
                     sumIn[4*SUM_W-1:2*SUM_W]);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_gaps();
        run_frame("gap1", 3, 1, 1);
        run_frame("gap2", 3, 1, 1);
        run_frame("gap3", 2, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        logic [NODES*SUM_W-1:0] prev;
        int tc;
        fill_random();
        for (int i = 0; i < 5; i++) send(qa[i], qw[i], 0);
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL clear_busy_pre: got %b need 1", busy);
        else n_pass++;
        prev = sumIn;
        tc = trig_cnt;
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd55;
        in_weight = 8'd77;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (busy !== 1'b0 || trigger !== 1'b0 || sumIn !== prev)
            $display("FAIL clear_state: busy=%b trg=%b sum=%h need 0 0 %h",
                     busy, trigger, sumIn, prev);
        else n_pass++;
        run_frame("after_clear", 1, 0, 1);
        @(negedge clk);
        #1;
        n_total++;
        if (trig_cnt !== tc + 1)
            $display("FAIL clear_trig_cnt: got %0d need %0d",
                     trig_cnt - tc, 1);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        fill_random();
        for (int i = 0; i < 10; i++) send(qa[i], qw[i], 0);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++;
        if (sumIn !== '0 || trigger !== 1'b0 || busy !== 1'b0 ||
            in_ready !== 1'b0)
            $display("FAIL rst_mid_async: sum=%h trg=%b busy=%b rdy=%b",
                     sumIn, trigger, busy, in_ready);
        else n_pass++;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL rst_mid_ready: got %b need 1", in_ready);
        else n_pass++;
        run_frame("post_reset", 0, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int tc;
        tc = trig_cnt;
        trig_cyc.delete();
        run_frame("b2b1", 0, 1, 1);
        run_frame("b2b2", 0, 1, 1);
        run_frame("b2b3", 0, 0, 1);
        @(negedge clk);
        #1;
        n_total++;
        if (trig_cnt - tc !== 3)
            $display("FAIL b2b_count: got %0d need 3", trig_cnt - tc);
        else n_pass++;
        n_total++;
        if (trig_cyc.size() != 3)
            $display("FAIL b2b_spacing: got %0d pulses need 3",
                     trig_cyc.size());
        else if (trig_cyc[1] - trig_cyc[0] != NB + 1 ||
                 trig_cyc[2] - trig_cyc[1] != NB + 1)
            $display("FAIL b2b_spacing: got %0d,%0d need %0d",
                     trig_cyc[1] - trig_cyc[0],
                     trig_cyc[2] - trig_cyc[1], NB + 1);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gaps();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        n_total++;
        if (stable_err !== 0)
            $display("FAIL sum_stable: got %0d changes need 0", stable_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
